// File: rtl/pse_pkg.sv
// pse_pkg: shared state type, default address map and saturating add for pattern_scan_engine
package pse_pkg;
  typedef enum logic [2:0] {IDLE, RD_PAT, STREAM, DRAIN, WR0, WR1, WR2, DONE} state_t;
  localparam int DEF_STR_BASE = 0;
  localparam int DEF_PAT_ADDR = 32;
  localparam int DEF_RES_BASE = 33;
  function automatic logic [63:0] sat_add(input logic [63:0] a, input logic [3:0] b, input int w);
    logic [63:0] m;
    logic [63:0] s;
    m = (w >= 64) ? '1 : (64'd1 << w) - 64'd1;
    s = a + 64'(b);
    return (s > m) ? m : s;
  endfunction
endpackage

// File: rtl/window_matcher.sv
// window_matcher: counts pattern matches in one byte and across the previous-byte boundary
module window_matcher import pse_pkg::*; (
  input  logic [14:0] hb,
  input  logic [7:0]  pattern,
  input  logic [3:0]  len,
  input  logic        first,
  output logic [3:0]  in_cnt,
  output logic        hit,
  output logic [3:0]  cross_cnt
);
  logic [7:0] mask;
  logic [7:0] pr;
  logic [3:0] all_cnt;
  always_comb begin
    mask = 8'((9'd1 << len) - 9'd1);
    pr = pattern >> (4'd8 - len);
    in_cnt = '0;
    all_cnt = '0;
    for (int e = 0; e < 8; e++) begin
      if ((8'(hb >> e) & mask) == pr) begin
        all_cnt = all_cnt + 4'd1;
        if (e <= 8 - int'(len)) in_cnt = in_cnt + 4'd1;
      end
    end
  end
  assign hit = in_cnt != '0;
  assign cross_cnt = first ? in_cnt : all_cnt;
endmodule

// File: rtl/pattern_scan_engine.sv
// pattern_scan_engine: scans a memory bit string for a left-aligned pattern and writes back three saturating counts
module pattern_scan_engine import pse_pkg::*; #(
  parameter int N_BYTES  = 32,
  parameter int ADDR_W   = 8,
  parameter int STR_BASE = DEF_STR_BASE,
  parameter int PAT_ADDR = DEF_PAT_ADDR,
  parameter int RES_BASE = DEF_RES_BASE,
  parameter int CNT_W    = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [3:0]        pat_len,
  output logic              done,
  output logic              busy,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_raddr,
  input  logic [7:0]        mem_rdata,
  output logic              mem_wr_en,
  output logic [ADDR_W-1:0] mem_waddr,
  output logic [7:0]        mem_wdata
);
  localparam int K_W = $clog2(N_BYTES) + 1;
  state_t state;
  state_t next;
  logic [K_W-1:0] k;
  logic [3:0] len;
  logic [7:0] pat;
  logic [6:0] h;
  logic [CNT_W-1:0] ctb;
  logic [CNT_W-1:0] cto;
  logic [CNT_W-1:0] cts;
  logic [3:0] in_cnt;
  logic [3:0] cross_cnt;
  logic hit;
  logic accept;
  logic proc;
  logic legal;
  function automatic logic [7:0] to_byte(input logic [CNT_W-1:0] c, input logic ok);
    return !ok ? 8'd0 : (64'(c) > 64'd255) ? 8'hFF : 8'(c);
  endfunction
  assign accept = (state == IDLE || state == DONE) && start;
  assign proc = (state == STREAM && k != '0) || state == DRAIN;
  assign legal = len != 4'd0 && len <= 4'd8;
  assign done = state == DONE;
  assign busy = !(state == IDLE || state == DONE);
  window_matcher u_wm (
    .hb({h, mem_rdata}),
    .pattern(pat),
    .len(len),
    .first(state == STREAM && k == K_W'(1)),
    .in_cnt(in_cnt),
    .hit(hit),
    .cross_cnt(cross_cnt)
  );
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else state <= next;
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      k <= '0;
      len <= '0;
      pat <= '0;
      h <= '0;
      ctb <= '0;
      cto <= '0;
      cts <= '0;
    end else begin
      k <= (state == STREAM) ? k + K_W'(1) : '0;
      if (accept) begin
        len <= pat_len;
        h <= '0;
        ctb <= '0;
        cto <= '0;
        cts <= '0;
      end
      if (state == STREAM && k == '0) pat <= mem_rdata;
      if (proc) begin
        ctb <= CNT_W'(sat_add(64'(ctb), in_cnt, CNT_W));
        cto <= CNT_W'(sat_add(64'(cto), 4'(hit), CNT_W));
        cts <= CNT_W'(sat_add(64'(cts), cross_cnt, CNT_W));
        h <= mem_rdata[6:0];
      end
    end
  end
  always_comb begin
    next = state;
    mem_rd_en = 1'b0;
    mem_raddr = '0;
    mem_wr_en = 1'b0;
    mem_waddr = '0;
    mem_wdata = '0;
    case (state)
      IDLE, DONE: next = start ? RD_PAT : state;
      RD_PAT: begin
        next = STREAM;
        mem_rd_en = 1'b1;
        mem_raddr = ADDR_W'(PAT_ADDR);
      end
      STREAM: begin
        next = (k == K_W'(N_BYTES - 1)) ? DRAIN : STREAM;
        mem_rd_en = 1'b1;
        mem_raddr = ADDR_W'(STR_BASE) + ADDR_W'(k);
      end
      DRAIN: next = WR0;
      WR0: begin
        next = WR1;
        mem_wr_en = 1'b1;
        mem_waddr = ADDR_W'(RES_BASE);
        mem_wdata = to_byte(ctb, legal);
      end
      WR1: begin
        next = WR2;
        mem_wr_en = 1'b1;
        mem_waddr = ADDR_W'(RES_BASE + 1);
        mem_wdata = to_byte(cto, legal);
      end
      WR2: begin
        next = DONE;
        mem_wr_en = 1'b1;
        mem_waddr = ADDR_W'(RES_BASE + 2);
        mem_wdata = to_byte(cts, legal);
      end
      default: next = IDLE;
    endcase
  end
endmodule

// File: tb/tb_pattern_scan_engine.sv
// tb_pattern_scan_engine: scoreboard bench for pattern_scan_engine with a bit-level reference model
module tb_pattern_scan_engine;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic start = 1'b0;
  logic [3:0] pat_len = '0;
  logic done;
  logic busy;
  logic mem_rd_en;
  logic [7:0] mem_raddr;
  logic [7:0] mem_rdata = '0;
  logic mem_wr_en;
  logic [7:0] mem_waddr;
  logic [7:0] mem_wdata;
  logic [7:0] mem [256];
  logic [15:0] exp_q[$];
  logic [15:0] got_q[$];
  int vectors = 0;
  int miscompares = 0;
  pattern_scan_engine dut (
    .clk(clk),
    .reset_n(reset_n),
    .start(start),
    .pat_len(pat_len),
    .done(done),
    .busy(busy),
    .mem_rd_en(mem_rd_en),
    .mem_raddr(mem_raddr),
    .mem_rdata(mem_rdata),
    .mem_wr_en(mem_wr_en),
    .mem_waddr(mem_waddr),
    .mem_wdata(mem_wdata)
  );
  always #5 clk = ~clk;
  always @(posedge clk) if (mem_rd_en) mem_rdata <= mem[mem_raddr];
  always @(negedge clk) if (mem_wr_en) got_q.push_back({mem_waddr, mem_wdata});
  function automatic logic [7:0] sat(input int v);
    return (v > 255) ? 8'd255 : 8'(v);
  endfunction
  task automatic fill(input logic [7:0] v, input logic [7:0] pat);
    for (int i = 0; i < 32; i++) mem[i] = v;
    mem[32] = pat;
  endtask
  task automatic push_exp(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
    exp_q.push_back({8'd33, a});
    exp_q.push_back({8'd34, b});
    exp_q.push_back({8'd35, c});
  endtask
  task automatic push_model(input int l);
    int ctb;
    int cto;
    int cts;
    int n;
    int ok;
    logic [0:255] s;
    logic [7:0] pat;
    ctb = 0;
    cto = 0;
    cts = 0;
    pat = mem[32];
    for (int i = 0; i < 32; i++) s[8*i +: 8] = mem[i];
    if (l >= 1 && l <= 8) begin
      for (int i = 0; i < 32; i++) begin
        n = 0;
        for (int j = 0; j <= 8 - l; j++) begin
          ok = 1;
          for (int q = 0; q < l; q++) if (s[8*i+j+q] != pat[7-q]) ok = 0;
          n += ok;
        end
        ctb += n;
        cto += (n != 0) ? 1 : 0;
      end
      for (int p = 0; p <= 256 - l; p++) begin
        ok = 1;
        for (int q = 0; q < l; q++) if (s[p+q] != pat[7-q]) ok = 0;
        cts += ok;
      end
    end
    push_exp(sat(ctb), sat(cto), sat(cts));
  endtask
  task automatic run_scan(input string name, input logic [3:0] l, input int extra_k);
    int cyc;
    logic [15:0] e;
    logic [15:0] g;
    got_q.delete();
    @(negedge clk);
    start = 1'b1;
    pat_len = l;
    @(posedge clk);
    #1 start = 1'b0;
    for (cyc = 1; cyc <= 60; cyc++) begin
      @(posedge clk);
      #1;
      start = (cyc == extra_k + 1);
      pat_len = start ? 4'd1 : l;
      if (done) break;
    end
    start = 1'b0;
    vectors++;
    if (cyc != 37) begin
      miscompares++;
      $display("FAIL %s latency: got %0d edges expected 37", name, cyc);
    end
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("FAIL %s busy_after_done: got %b expected 0", name, busy);
    end
    repeat (2) @(negedge clk);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      vectors++;
      if (got_q.size() == 0) begin
        miscompares++;
        $display("FAIL %s write: got none expected addr %0d data %0d", name, e[15:8], e[7:0]);
      end else begin
        g = got_q.pop_front();
        if (g !== e) begin
          miscompares++;
          $display("FAIL %s write: got addr %0d data %0d expected addr %0d data %0d", name, g[15:8], g[7:0], e[15:8], e[7:0]);
        end
      end
    end
    vectors++;
    if (got_q.size() != 0) begin
      miscompares++;
      $display("FAIL %s extra_writes: got %0d expected 0", name, got_q.size());
    end
  endtask
  task automatic test_reset;
    repeat (3) @(negedge clk);
    vectors++;
    if ({done, busy, mem_rd_en, mem_wr_en} !== 4'b0) begin
      miscompares++;
      $display("FAIL reset_flags: got %b expected 0000", {done, busy, mem_rd_en, mem_wr_en});
    end
    vectors++;
    if ({mem_raddr, mem_waddr, mem_wdata} !== 24'h0) begin
      miscompares++;
      $display("FAIL reset_bus: got %h expected 000000", {mem_raddr, mem_waddr, mem_wdata});
    end
    reset_n = 1'b1;
  endtask
  task automatic test_zeros(input string name, input int extra_k);
    fill(8'h00, 8'h00);
    push_exp(8'd128, 8'd32, 8'd252);
    run_scan(name, 4'd5, extra_k);
  endtask
  task automatic test_alternating;
    fill(8'h55, 8'hA8);
    push_exp(8'd64, 8'd32, 8'd126);
    run_scan("alternating", 4'd5, -1);
  endtask
  task automatic test_single_hit;
    fill(8'h00, 8'hA5);
    mem[5] = 8'hA5;
    push_exp(8'd1, 8'd1, 8'd1);
    run_scan("single_hit", 4'd8, -1);
  endtask
  task automatic test_saturation;
    fill(8'hFF, 8'h80);
    push_exp(8'd255, 8'd32, 8'd255);
    run_scan("saturation", 4'd1, -1);
  endtask
  task automatic test_illegal_len;
    fill(8'h00, 8'h00);
    push_exp(8'd0, 8'd0, 8'd0);
    run_scan("len0", 4'd0, -1);
    push_exp(8'd0, 8'd0, 8'd0);
    run_scan("len9", 4'd9, -1);
  endtask
  task automatic test_random;
    int l;
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < 32; i++) mem[i] = 8'($urandom) & 8'($urandom);
      mem[32] = 8'($urandom);
      l = $urandom_range(1, 8);
      push_model(l);
      run_scan("random", 4'(l), -1);
    end
  endtask
  task automatic test_reset_mid_run;
    fill(8'h00, 8'h00);
    got_q.delete();
    @(negedge clk);
    start = 1'b1;
    pat_len = 4'd5;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (11) @(posedge clk);
    #1 reset_n = 1'b0;
    #1;
    vectors++;
    if ({done, busy, mem_wr_en, mem_rd_en} !== 4'b0) begin
      miscompares++;
      $display("FAIL mid_reset_flags: got %b expected 0000", {done, busy, mem_wr_en, mem_rd_en});
    end
    repeat (4) @(negedge clk);
    vectors++;
    if (got_q.size() != 0) begin
      miscompares++;
      $display("FAIL mid_reset_writes: got %0d expected 0", got_q.size());
    end
    reset_n = 1'b1;
    test_zeros("after_reset", -1);
  endtask
  initial begin
    test_reset();
    test_zeros("zeros", -1);
    test_alternating();
    test_single_hit();
    test_saturation();
    test_reset_mid_run();
    test_zeros("start_while_busy", 3);
    test_illegal_len();
    test_random();
    test_zeros("back_to_back", -1);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
